// File: rtl/square.sv
// Pipelined per-bit generate/propagate with group generate/propagate across WIDTH bits.
// LATENCY register stages; valid travels with the data and gates every data register.
module square #(
   parameter int WIDTH   = 1,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] Ai,
   input  logic [WIDTH-1:0] Bi,
   output logic             out_valid,
   output logic [WIDTH-1:0] G,
   output logic [WIDTH-1:0] P,
   output logic             GG,
   output logic             PG
);

   // Handshake: in_valid=1 means Ai/Bi are taken at this rising edge; there is no
   // ready, every cycle can accept. out_valid=1 marks a fresh result; otherwise the
   // outputs hold the last valid result.

   logic [WIDTH-1:0] g_d;
   logic [WIDTH-1:0] p_d;
   logic             gg_d;
   logic             pg_d;

   always_comb begin
      g_d  = Ai & Bi;
      p_d  = Ai ^ Bi;
      pg_d = &p_d;
      gg_d = 1'b0;
      // Ripple the group carry upward from bit 0 with carry-in 0.
      for (int i = 0; i < WIDTH; i++) begin
         gg_d = g_d[i] | (p_d[i] & gg_d);
      end
   end

   logic [LATENCY-1:0] v_q;
   logic [WIDTH-1:0]   g_q  [LATENCY];
   logic [WIDTH-1:0]   p_q  [LATENCY];
   logic [LATENCY-1:0] gg_q;
   logic [LATENCY-1:0] pg_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q  <= '0;
         gg_q <= '0;
         pg_q <= '0;
         for (int s = 0; s < LATENCY; s++) begin
            g_q[s] <= '0;
            p_q[s] <= '0;
         end
      end else begin
         v_q[0] <= in_valid;
         if (in_valid) begin
            g_q[0]  <= g_d;
            p_q[0]  <= p_d;
            gg_q[0] <= gg_d;
            pg_q[0] <= pg_d;
         end
         for (int s = 1; s < LATENCY; s++) begin
            v_q[s] <= v_q[s-1];
            if (v_q[s-1]) begin
               g_q[s]  <= g_q[s-1];
               p_q[s]  <= p_q[s-1];
               gg_q[s] <= gg_q[s-1];
               pg_q[s] <= pg_q[s-1];
            end
         end
      end
   end

   assign out_valid = v_q[LATENCY-1];
   assign G         = g_q[LATENCY-1];
   assign P         = p_q[LATENCY-1];
   assign GG        = gg_q[LATENCY-1];
   assign PG        = pg_q[LATENCY-1];

endmodule

// File: tb/tb_square.sv
// Directed bench for square: three instances (W1/L1, W8/L2, W8/L3) sharing clock and reset.
module tb_square;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
   logic       ov1, g1, p1, gg1, pg1;

   logic       v2 = 1'b0;
   logic [7:0] a2 = '0, b2 = '0;
   logic       ov2, gg2, pg2;
   logic [7:0] g2, p2;

   logic       v3 = 1'b0;
   logic [7:0] a3 = '0, b3 = '0;
   logic       ov3, gg3, pg3;
   logic [7:0] g3, p3;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   square #(.WIDTH(1), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .Ai(a1), .Bi(b1),
      .out_valid(ov1), .G(g1), .P(p1), .GG(gg1), .PG(pg1));

   square #(.WIDTH(8), .LATENCY(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .Ai(a2), .Bi(b2),
      .out_valid(ov2), .G(g2), .P(p2), .GG(gg2), .PG(pg2));

   square #(.WIDTH(8), .LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(v3), .Ai(a3), .Bi(b3),
      .out_valid(ov3), .G(g3), .P(p3), .GG(gg3), .PG(pg3));

   // Reference for the 8-bit group carry: the carry-out of a plain addition.
   function automatic logic model_gg(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[8];
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({ov1, g1, p1, gg1, pg1} !== 5'b0) begin failures++; $display("FAIL reset_dut1 got %b exp 00000", {ov1, g1, p1, gg1, pg1}); end
      checks++; if ({ov2, g2, p2, gg2, pg2} !== 19'b0) begin failures++; $display("FAIL reset_dut2 got %h exp 0", {ov2, g2, p2, gg2, pg2}); end
      checks++; if ({ov3, g3, p3, gg3, pg3} !== 19'b0) begin failures++; $display("FAIL reset_dut3 got %h exp 0", {ov3, g3, p3, gg3, pg3}); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_w1();
      logic [3:0] va  = 4'b1100;
      logic [3:0] vb  = 4'b1010;
      logic [3:0] eg  = 4'b1000;
      logic [3:0] ep  = 4'b0110;
      logic [3:0] egg = 4'b1000;
      logic [3:0] epg = 4'b0110;
      for (int k = 3; k >= 0; k--) begin
         @(negedge clk);
         v1 = 1'b1; a1 = va[k]; b1 = vb[k];
         @(negedge clk);
         v1 = 1'b0; a1 = 1'bx; b1 = 1'bx;
         checks++; if (ov1 !== 1'b1) begin failures++; $display("FAIL w1_valid[%0d] got %b exp 1", k, ov1); end
         checks++; if ({g1, p1, gg1, pg1} !== {eg[k], ep[k], egg[k], epg[k]}) begin
            failures++; $display("FAIL w1_data[%0d] got %b exp %b", k, {g1, p1, gg1, pg1}, {eg[k], ep[k], egg[k], epg[k]}); end
         @(negedge clk);
         checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL w1_idle[%0d] got %b exp 0", k, ov1); end
         checks++; if ({g1, p1, gg1, pg1} !== {eg[k], ep[k], egg[k], epg[k]}) begin
            failures++; $display("FAIL w1_hold[%0d] got %b exp %b", k, {g1, p1, gg1, pg1}, {eg[k], ep[k], egg[k], epg[k]}); end
      end
   endtask

   task automatic test_w8();
      logic [7:0] va  [4] = '{8'hF0, 8'hFF, 8'h0F, 8'hFF};
      logic [7:0] vb  [4] = '{8'h3C, 8'h00, 8'h01, 8'h01};
      logic [7:0] eg  [4] = '{8'h30, 8'h00, 8'h01, 8'h01};
      logic [7:0] ep  [4] = '{8'hCC, 8'hFF, 8'h0E, 8'hFE};
      logic [3:0] egg = 4'b1001;
      logic [3:0] epg = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         v2 = 1'b1; a2 = va[k]; b2 = vb[k];
         @(negedge clk);
         v2 = 1'b0; a2 = 'x; b2 = 'x;
         checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL w8_early[%0d] got %b exp 0", k, ov2); end
         @(negedge clk);
         checks++; if (ov2 !== 1'b1) begin failures++; $display("FAIL w8_valid[%0d] got %b exp 1", k, ov2); end
         checks++; if ({g2, p2} !== {eg[k], ep[k]}) begin
            failures++; $display("FAIL w8_gp[%0d] got G=%h P=%h exp G=%h P=%h", k, g2, p2, eg[k], ep[k]); end
         checks++; if ({gg2, pg2} !== {egg[3-k], epg[3-k]}) begin
            failures++; $display("FAIL w8_group[%0d] got GG=%b PG=%b exp GG=%b PG=%b", k, gg2, pg2, egg[3-k], epg[3-k]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q[$];
      logic       vin [24];
      logic [7:0] va  [24];
      logic [7:0] vb  [24];
      logic [7:0] last_a = '0, last_b = '0;
      logic [7:0] ea, eb;
      logic       held_zero = 1'b1;
      for (int c = 0; c < 24; c++) begin
         vin[c] = (c < 8) || (c == 9);
         va[c]  = 8'(c * 37 + 5);
         vb[c]  = 8'(c * 91 + 200);
      end
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (c >= 3 && vin[c-3]) begin
            ea = exp_q.pop_front();
            eb = exp_q.pop_front();
            last_a = ea; last_b = eb; held_zero = 1'b0;
            checks++; if (ov3 !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got %b exp 1", c, ov3); end
         end else begin
            checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL b2b_gap[%0d] got %b exp 0", c, ov3); end
         end
         if (!held_zero) begin
            checks++; if ({g3, p3, gg3, pg3} !== {last_a & last_b, last_a ^ last_b, model_gg(last_a, last_b), &(last_a ^ last_b)}) begin
               failures++; $display("FAIL b2b_data[%0d] got G=%h P=%h GG=%b PG=%b exp A=%h B=%h", c, g3, p3, gg3, pg3, last_a, last_b); end
         end
         if (vin[c]) begin
            v3 = 1'b1; a3 = va[c]; b3 = vb[c];
            exp_q.push_back(va[c]);
            exp_q.push_back(vb[c]);
         end else begin
            v3 = 1'b0; a3 = 'x; b3 = 'x;
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain got %0d left exp 0", exp_q.size()); end
   endtask

   task automatic test_reset_midflight();
      @(negedge clk);
      v3 = 1'b1; a3 = 8'hF0; b3 = 8'h3C;
      @(negedge clk);
      a3 = 8'hFF; b3 = 8'h00;
      @(negedge clk);
      v3 = 1'b0; a3 = 'x; b3 = 'x;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({ov3, g3, p3, gg3, pg3} !== 19'b0) begin failures++; $display("FAIL async_clear_dut3 got %h exp 0", {ov3, g3, p3, gg3, pg3}); end
      checks++; if ({ov2, g2, p2, gg2, pg2} !== 19'b0) begin failures++; $display("FAIL async_clear_dut2 got %h exp 0", {ov2, g2, p2, gg2, pg2}); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL flush_valid[%0d] got %b exp 0", c, ov3); end
         checks++; if ({g3, p3} !== 16'h0) begin failures++; $display("FAIL flush_data[%0d] got %h exp 0", c, {g3, p3}); end
      end
      v3 = 1'b1; a3 = 8'h0F; b3 = 8'h01;
      @(negedge clk);
      v3 = 1'b0; a3 = 'x; b3 = 'x;
      @(negedge clk);
      checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL post_reset_early got %b exp 0", ov3); end
      @(negedge clk);
      checks++; if (ov3 !== 1'b1) begin failures++; $display("FAIL post_reset_valid got %b exp 1", ov3); end
      checks++; if ({g3, p3, gg3, pg3} !== {8'h01, 8'h0E, 1'b0, 1'b0}) begin
         failures++; $display("FAIL post_reset_data got G=%h P=%h GG=%b PG=%b exp G=01 P=0e GG=0 PG=0", g3, p3, gg3, pg3); end
   endtask

   initial begin
      test_reset();
      test_w1();
      test_w8();
      test_back_to_back();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
